// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models latency with a busy counter,
// and raises the D-stage stall. Optional `MDU_CANCEL_EN adds a cancel input for flushes.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_in_d,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;
    logic        cancel_w;

`ifdef MDU_CANCEL_EN
    assign cancel_w = cancel;
`else
    assign cancel_w = 1'b0;
`endif

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_signed, neg_a, neg_b;
    logic        [31:0] div_a, div_b, quot_u, rem_u, quot, rem;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // One unsigned divider on magnitudes; signs restored afterwards. This also makes
    // 0x80000000 / -1 wrap to 0x80000000 with remainder 0 without special casing.
    assign div_signed = (md_op == OP_DIV);
    assign neg_a      = div_signed & rs_data[31];
    assign neg_b      = div_signed & rt_data[31];
    assign div_a      = neg_a ? (~rs_data + 32'd1) : rs_data;
    assign div_b      = (rt_data == 32'd0) ? 32'd1 : (neg_b ? (~rt_data + 32'd1) : rt_data);
    assign quot_u     = div_a / div_b;
    assign rem_u      = div_a % div_b;
    assign quot       = (neg_a ^ neg_b) ? (~quot_u + 32'd1) : quot_u;
    assign rem        = neg_a ? (~rem_u + 32'd1) : rem_u;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (start && !cancel_w) begin
                    case (md_op)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            pend_wr_d = 1'b1;
                            cnt_d     = 4'(MULT_CYCLES);
                            state_d   = RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = rem;
                            pend_lo_d = quot;
                            pend_wr_d = (rt_data != 32'd0);
                            cnt_d     = 4'(DIV_CYCLES);
                            state_d   = RUN;
                        end
                        OP_MTHI: hi_d = rs_data;
                        OP_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel_w) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = md_in_d & (start | busy);

endmodule
